// File: rtl/gol_window.sv
// gol_window: streaming 3x3 neighbourhood generator for the Game-of-Life datapath.
// Cells arrive serially in raster order. A shift chain of 2*WIDTH+2 cells holds the
// two previous rows plus the window; together with the incoming cell it exposes the
// full 3x3 neighbourhood of the cell WIDTH+1 positions back. Neighbours that fall
// outside the grid are masked to dead at the output. After the last cell of a frame,
// WIDTH+1 dead padding cells are injected to drain the pending windows.
module gol_window #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_cell,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic                      center,
  output logic                      a,
  output logic                      b,
  output logic                      c,
  output logic                      d,
  output logic                      e,
  output logic                      f,
  output logic                      g,
  output logic                      h,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y
);

  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);
  // Stored history: two full rows plus two cells; the incoming cell completes the window.
  localparam int SR_LEN = WIDTH + WIDTH + 32'sd2;

  // Tap positions in the extended chain {history, incoming}; index 0 is the newest cell.
  localparam int I_H   = 32'sd0;
  localparam int I_G   = 32'sd1;
  localparam int I_F   = 32'sd2;
  localparam int I_E   = WIDTH;
  localparam int I_CTR = WIDTH + 32'sd1;
  localparam int I_D   = WIDTH + 32'sd2;
  localparam int I_C   = WIDTH + WIDTH;
  localparam int I_B   = WIDTH + WIDTH + 32'sd1;
  localparam int I_A   = WIDTH + WIDTH + 32'sd2;

  localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
  localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
  localparam logic [YW-1:0] Y_ONE  = {{(YW - 32'sd1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 32'sd1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 32'sd1);

  // Window bit order: {center, a, b, c, d, e, f, g, h}
  localparam logic [8:0] KEEP_COL_FIRST = 9'h16B;  // drop a, d, f
  localparam logic [8:0] KEEP_COL_LAST  = 9'h1D6;  // drop c, e, h
  localparam logic [8:0] KEEP_ROW_FIRST = 9'h11F;  // drop a, b, c
  localparam logic [8:0] KEEP_ROW_LAST  = 9'h1F8;  // drop f, g, h

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q;
  logic [SR_LEN-1:0]   sr_q;
  logic [XW-1:0]       ix_q;
  logic [YW-1:0]       iy_q;
  logic [XW-1:0]       ox_q;
  logic [YW-1:0]       oy_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [8:0]          win_q;
  logic [XW-1:0]       out_x_q;
  logic [YW-1:0]       out_y_q;

  logic                accept_s;
  logic                step_s;
  logic                emit_s;
  logic                new_cell_s;
  logic [SR_LEN:0]     sr_d;
  logic [8:0]          raw_win_s;
  logic [8:0]          win_d;

  // Force neighbours outside the grid to dead; corners combine two rules.
  function automatic logic [8:0] mask_window(
    input logic [8:0] raw,
    input logic       col_first,
    input logic       col_last,
    input logic       row_first,
    input logic       row_last
  );
    logic [8:0] keep;
    keep = 9'h1FF;
    if (col_first) keep = keep & KEEP_COL_FIRST;
    else           keep = keep;
    if (col_last)  keep = keep & KEEP_COL_LAST;
    else           keep = keep;
    if (row_first) keep = keep & KEEP_ROW_FIRST;
    else           keep = keep;
    if (row_last)  keep = keep & KEEP_ROW_LAST;
    else           keep = keep;
    return raw & keep;
  endfunction

  // Decide whether the chain steps this cycle and build the masked window it exposes.
  always_comb begin
    accept_s = in_valid & in_ready_q;
    if (state_q == ST_FLUSH) begin
      step_s     = 1'b1;
      emit_s     = 1'b1;
      new_cell_s = 1'b0;
    end else begin
      step_s     = accept_s;
      emit_s     = accept_s & (state_q == ST_RUN);
      new_cell_s = in_cell;
    end
    sr_d      = {sr_q, new_cell_s};
    raw_win_s = {sr_d[I_CTR], sr_d[I_A], sr_d[I_B], sr_d[I_C], sr_d[I_D],
                 sr_d[I_E], sr_d[I_F], sr_d[I_G], sr_d[I_H]};
    win_d     = mask_window(raw_win_s, ox_q == X_ZERO, ox_q == X_LAST,
                            oy_q == Y_ZERO, oy_q == Y_LAST);
  end

  // Frame sequencing, coordinate counters, line buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      sr_q        <= {SR_LEN{1'b0}};
      ix_q        <= X_ZERO;
      iy_q        <= Y_ZERO;
      ox_q        <= X_ZERO;
      oy_q        <= Y_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      win_q       <= 9'h000;
      out_x_q     <= X_ZERO;
      out_y_q     <= Y_ZERO;
    end else begin
      out_valid_q <= emit_s;
      if (step_s) begin
        sr_q <= sr_d[SR_LEN-1:0];
      end
      if (accept_s) begin
        if (ix_q == X_LAST) begin
          ix_q <= X_ZERO;
          iy_q <= (iy_q == Y_LAST) ? Y_ZERO : iy_q + 1'b1;
        end else begin
          ix_q <= ix_q + 1'b1;
        end
      end
      if (emit_s) begin
        win_q   <= win_d;
        out_x_q <= ox_q;
        out_y_q <= oy_q;
        if (ox_q == X_LAST) begin
          ox_q <= X_ZERO;
          oy_q <= (oy_q == Y_LAST) ? Y_ZERO : oy_q + 1'b1;
        end else begin
          ox_q <= ox_q + 1'b1;
        end
      end
      case (state_q)
        ST_FILL: begin
          // Cell index WIDTH is the last one needed before window (0,0) can form.
          if (accept_s && ix_q == X_ZERO && iy_q == Y_ONE) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_s && ix_q == X_LAST && iy_q == Y_LAST) begin
            state_q    <= ST_FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (ox_q == X_LAST && oy_q == Y_LAST) begin
            state_q    <= ST_FILL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign center    = win_q[8];
  assign a         = win_q[7];
  assign b         = win_q[6];
  assign c         = win_q[5];
  assign d         = win_q[4];
  assign e         = win_q[3];
  assign f         = win_q[2];
  assign g         = win_q[1];
  assign h         = win_q[0];
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_gol_window.sv
// Directed bench for gol_window on a 4x4 grid: hand-computed window table plus
// multi-cycle sequences for flow control, gaps, back-to-back frames and reset.
module tb_gol_window;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_cell;
  logic       in_ready;
  logic       out_valid;
  logic       center, a, b, c, d, e, f, g, h;
  logic [1:0] out_x;
  logic [1:0] out_y;

  always #5 clk = ~clk;

  gol_window #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_cell  (in_cell),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .center   (center),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .out_x    (out_x),
    .out_y    (out_y)
  );

  typedef struct {
    int         fsel;   // 0 = single live cell frame, 1 = all-ones frame
    int         idx;    // raster index of the window
    logic [8:0] want;   // {center,a,b,c,d,e,f,g,h}
  } vec_t;

  vec_t       tab [17];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] cap_win [256];
  int         cap_x   [256];
  int         cap_y   [256];
  int         cap_cyc [256];
  int         ncap = 0;
  int         gap_viol = 0;
  logic       prev_acc = 1'b0;
  logic       prev_flush = 1'b0;
  logic [8:0] win_s;

  assign win_s = {center, a, b, c, d, e, f, g, h};

  // Cycle counter advanced at each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every emitted window and flag pulses not caused by an acceptance or flush.
  always @(negedge clk) begin
    if (out_valid && ncap < 256) begin
      cap_win[ncap[7:0]] <= win_s;
      cap_x[ncap[7:0]]   <= int'(out_x);
      cap_y[ncap[7:0]]   <= int'(out_y);
      cap_cyc[ncap[7:0]] <= cyc;
      ncap               <= ncap + 1;
      if (!prev_acc && !prev_flush) gap_viol <= gap_viol + 1;
    end
    prev_acc   <= in_valid && in_ready && !rst;
    prev_flush <= !in_ready && !rst;
  end

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic cell_at(input logic [15:0] grid, input int x, input int y);
    int k;
    if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
    k = y * W + x;
    return grid[k[3:0]];
  endfunction

  function automatic logic [8:0] model_win(input logic [15:0] grid, input int x, input int y);
    return {cell_at(grid, x, y),
            cell_at(grid, x-1, y-1), cell_at(grid, x, y-1), cell_at(grid, x+1, y-1),
            cell_at(grid, x-1, y),                          cell_at(grid, x+1, y),
            cell_at(grid, x-1, y+1), cell_at(grid, x, y+1), cell_at(grid, x+1, y+1)};
  endfunction

  // Called at posedge+1; returns after the acceptance edge (again at posedge+1).
  task automatic push_cell(input logic v, output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_cell  = v;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_cell  = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] grid, input int max_gap, output int acc6);
    int acc;
    int gap;
    acc6 = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < W*H; i++) begin
      if (max_gap > 0) begin
        gap = $urandom_range(max_gap, 0);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      push_cell(grid[i], acc);
      if (i == 5) acc6 = acc;
    end
  endtask

  task automatic frame_check(input string nm, input logic [15:0] grid, input int base);
    int t;
    int j;
    t = 0;
    while (ncap < base + W*H && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done"}, (ncap >= base + W*H) ? 1 : 0, 1);
    for (int i = 0; i < W*H; i++) begin
      j = base + i;
      chk($sformatf("%s_x[%0d]", nm, i), cap_x[j[7:0]], i % W);
      chk($sformatf("%s_y[%0d]", nm, i), cap_y[j[7:0]], i / W);
      chk($sformatf("%s_win[%0d]", nm, i), int'(cap_win[j[7:0]]),
          int'(model_win(grid, i % W, i / W)));
    end
  endtask

  initial begin
    logic [15:0] g_single, g_ones, g_zero, g_glider;
    int base_a, base_b, base_c, base_g0, base_g1, base_r;
    int acc6, lowc, nsnap, dummy, j;

    g_single = 16'h0020;  // cell (1,1)
    g_ones   = 16'hFFFF;
    g_zero   = 16'h0000;
    g_glider = 16'h0742;  // (1,0) (2,1) (0,2) (1,2) (2,2)

    // Single live cell at (1,1): each neighbour sees it in exactly one position.
    tab[0]  = '{0, 0,  9'h001};  // (0,0) h
    tab[1]  = '{0, 1,  9'h002};  // (1,0) g
    tab[2]  = '{0, 2,  9'h004};  // (2,0) f
    tab[3]  = '{0, 4,  9'h008};  // (0,1) e
    tab[4]  = '{0, 5,  9'h100};  // (1,1) center only
    tab[5]  = '{0, 6,  9'h010};  // (2,1) d
    tab[6]  = '{0, 8,  9'h020};  // (0,2) c
    tab[7]  = '{0, 9,  9'h040};  // (1,2) b
    tab[8]  = '{0, 10, 9'h080};  // (2,2) a
    tab[9]  = '{0, 15, 9'h000};  // (3,3) far away
    // All ones: corners 3 neighbours, edges 5, interior 8.
    tab[10] = '{1, 0,  9'h10B};  // (0,0) e g h
    tab[11] = '{1, 3,  9'h116};  // (3,0) d f g
    tab[12] = '{1, 12, 9'h168};  // (0,3) b c e
    tab[13] = '{1, 15, 9'h1D0};  // (3,3) a b d
    tab[14] = '{1, 1,  9'h11F};  // (1,0) top edge
    tab[15] = '{1, 4,  9'h16B};  // (0,1) left edge
    tab[16] = '{1, 5,  9'h1FF};  // (1,1) interior

    rst = 1'b1;
    in_valid = 1'b0;
    in_cell = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_win", int'(win_s), 0);
    chk("rst_xy", int'({out_x, out_y}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single live cell, continuous input, with flow-control timing.
    base_a = ncap;
    push_frame(g_single, 0, acc6);
    lowc = 0;
    @(negedge clk);
    while (!in_ready && lowc < 30) begin
      lowc++;
      @(negedge clk);
    end
    chk("in_ready_low_cycles", lowc, W + 1);
    repeat (3) @(negedge clk);
    chk("count_single", ncap - base_a, W*H);
    chk("first_pulse_cycle", cap_cyc[base_a[7:0]], acc6);
    j = base_a + W*H - 1;
    chk("pulses_back_to_back", cap_cyc[j[7:0]] - cap_cyc[base_a[7:0]], W*H - 1);
    frame_check("single", g_single, base_a);

    // Back-to-back frames: all ones then all zeros.
    base_b = ncap;
    push_frame(g_ones, 0, dummy);
    push_frame(g_zero, 0, dummy);
    base_c = base_b + W*H;
    frame_check("ones", g_ones, base_b);
    frame_check("zeros", g_zero, base_c);

    for (int i = 0; i < 17; i++) begin
      j = ((tab[i].fsel == 0) ? base_a : base_b) + tab[i].idx;
      chk($sformatf("table[%0d]", i), int'(cap_win[j[7:0]]), int'(tab[i].want));
    end

    // Glider without gaps, then with random input gaps.
    base_g0 = ncap;
    push_frame(g_glider, 0, dummy);
    frame_check("glider", g_glider, base_g0);
    base_g1 = ncap;
    push_frame(g_glider, 3, dummy);
    frame_check("glider_gaps", g_glider, base_g1);
    chk("no_pulse_without_accept", gap_viol, 0);

    // Reset after 9 accepted cells, then a fresh frame.
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) push_cell(1'b1, dummy);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_win", int'(win_s), 0);
    chk("midrst_xy", int'({out_x, out_y}), 0);
    @(negedge clk);
    nsnap = ncap;
    repeat (6) @(negedge clk);
    chk("midrst_no_pulses", ncap - nsnap, 0);
    base_r = ncap;
    push_frame(g_glider, 0, dummy);
    frame_check("after_rst", g_glider, base_r);
    repeat (8) @(negedge clk);
    chk("count_after_rst", ncap - base_r, W*H);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
